fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  PC/fetch stage of the single-cycle WISC core. Holds the PC and drives the imem address.
//  Passes the fetched word to the decoder (opcode = instr[15:12]).
//  Consumes the decoder's Branch output, evaluates the ccc condition against the internal
//  N/Z/V flag register, and selects the next PC. Latches HLT.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  stall         in   1   hold PC, flags and halt this cycle
//  instr         in   16  word read combinationally from imem at pc_addr
//  branch        in   1   Branch from decoder (opcodes C=B, D=BR)
//  branch_reg    in   16  rs value used as the BR target
//  flag_wr_z     in   1   update Z (ADD,SUB,XOR,SLL,SRA,ROR)
//  flag_wr_nv    in   1   update N and V (ADD,SUB)
//  alu_z/n/v     in   1   flag values from the ALU for the current instruction
//  pc_addr       out  16  current PC (registered) to imem
//  instr_out     out  16  instr forwarded to decoder/regfile (combinational)
//  pc_plus2      out  16  pc_addr+2, used by PCS writeback
//  branch_taken  out  1   current instruction redirects PC (combinational)
//  halt          out  1   registered; high once HLT has retired
// BEHAVIOUR
//  - Reset: pc<=RESET_PC, flags NZV<=3'b000, halt<=0. Reset overrides stall.
//  - Latency: a flag write at edge k is visible to the branch fetched in cycle k+1.
//    No same-cycle flag forwarding.
//  - Condition on ccc=instr[11:9], using the registered flags:
//      000 NE  Z=0
//      001 EQ  Z=1
//      010 GT  Z=0&N=0
//      011 LT  N=1
//      100 GE  Z=1|(Z=0&N=0)
//      101 LE  N=1|Z=1
//      110 OV  V=1
//      111 always
//  - branch_taken = branch & cond & ~halt.
//  - Target when taken:
//      instr[12]=0 (B):  pc_plus2 + {{6{imm9[8]}},imm9,1'b0}, imm9=instr[8:0]
//      instr[12]=1 (BR): branch_reg
//    All PC arithmetic is 16-bit, wrapping mod 2^16. An odd target is taken unmodified.
//  - Next PC: halt | stall -> hold; taken -> target; else pc_plus2.
//  - HLT: opcode F in a non-stalled cycle -> halt<=1 at the edge and the PC stays on the HLT address.
//    halt is sticky until rst. While halt=1, flag writes and branches are ignored.
//  - Flags: on an edge with ~stall & ~halt, Z<=alu_z if flag_wr_z; N,V<=alu_n,alu_v if flag_wr_nv.
//  - Stall together with a branch: the branch is not taken. It re-evaluates when stall drops,
//    using the same flags.
//  - HLT on a taken-branch target executes normally the next cycle.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs instr_cnt[15:0] and taken_cnt[15:0].
//    Both reset to 0 and increment on each non-stalled, non-halted edge and on each taken branch
//    respectively. Both wrap at 16'hFFFF.
//    The HLT instruction itself is counted.
//  FETCH_PERF_CNT_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  - wisc_pkg: opcode constants (OP_ADD..OP_HLT, 4'h0..4'hF), ccc encodings (CC_NE..CC_UNCOND),
//    and the flag-vector bit indices.
//  - Sub-module branch_cond: combinational (ccc, N, Z, V) -> cond. Instantiated once.
//  - PC, flags, halt and optional counters are local registers.
// TESTING
//  1 rst high 2 cycles, then sequential 16'h0xxx words
//    -> pc_addr 0000,0002,0004; halt=0; branch_taken=0.
//  2 flag_wr_z=1, alu_z=1 at PC 0004, then B EQ imm9=9'h003 (16'hC203) at PC 0006
//    -> taken; next pc_addr=000E.
//  3 Z=0 and B EQ
//    -> not taken; next pc_addr=PC+2.
//    B NE imm9=9'h1FF at 0010 -> next pc_addr=0010.
//  4 BR always (ccc=111, 16'hDE00), branch_reg=1234
//    -> next pc_addr=1234.
//    B at FFFE with imm9=0 -> wraps to 0000.
//  5 HLT 16'hF000 at 0020 with stall=1 for 1 cycle
//    -> halt stays 0 while stalled; after the next edge halt=1, pc_addr=0020 and held 5 cycles.
//    Then rst -> pc_addr=RESET_PC, halt=0.
//  6 FETCH_PERF_CNT_EN: 10 instructions incl. 3 taken branches, ending in HLT
//    -> instr_cnt=10, taken_cnt=3, frozen afterwards.

Source files
------------

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wisc_pkg
// Purpose  : Shared constants for the WISC core: instruction opcodes,
//            branch condition (ccc) encodings and the bit positions of
//            N/Z/V in the packed flag vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wisc_pkg;

    // Opcodes, instr[15:12]
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Branch condition codes, instr[11:9]
    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_OV     = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Packed flag vector {N, Z, V}
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef logic [2:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond
// Purpose  : Combinational evaluation of a branch condition code against
//            the registered N/Z/V flags.
// Ports    : ccc  in  3  condition code from instr[11:9]
//            n    in  1  negative flag
//            z    in  1  zero flag
//            v    in  1  overflow flag
//            cond out 1  condition holds
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (ccc)
            CC_NE:     cond = ~z;
            CC_EQ:     cond = z;
            CC_GT:     cond = ~z & ~n;
            CC_LT:     cond = n;
            CC_GE:     cond = z | (~z & ~n);
            CC_LE:     cond = n | z;
            CC_OV:     cond = v;
            CC_UNCOND: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : PC/fetch stage of the single-cycle WISC core. Holds the PC,
//            forwards the fetched word, resolves B/BR against the N/Z/V
//            flag register and latches HLT.
// Params   : RESET_PC  PC value loaded on reset
// Ports    : clk, rst (sync, active high), stall
//            instr[15:0], branch, branch_reg[15:0]
//            flag_wr_z, flag_wr_nv, alu_z, alu_n, alu_v
//            pc_addr[15:0], instr_out[15:0], pc_plus2[15:0]
//            branch_taken, halt
//            instr_cnt[15:0], taken_cnt[15:0] (FETCH_PERF_CNT_EN only)
// Config   : FETCH_PERF_CNT_EN adds retired-instruction and taken-branch
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [15:0] instr,
    input  logic        branch,
    input  logic [15:0] branch_reg,
    input  logic        flag_wr_z,
    input  logic        flag_wr_nv,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    output logic [15:0] pc_addr,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2,
    output logic        branch_taken,
    output logic        halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] instr_cnt,
    output logic [15:0] taken_cnt
`endif
);

    logic [15:0] r_pc;
    flags_t      r_flags;
    logic        r_halt;

    logic [15:0] w_pc_plus2;
    logic [15:0] w_imm_off;
    logic [15:0] w_target;
    logic        w_cond;
    logic        w_taken;
    logic        w_adv;
    logic        w_is_hlt;

    assign w_pc_plus2 = r_pc + 16'd2;
    // imm9 is a word offset: sign-extend and scale by 2
    assign w_imm_off  = {{6{instr[8]}}, instr[8:0], 1'b0};
    assign w_target   = instr[12] ? branch_reg : (w_pc_plus2 + w_imm_off);
    assign w_is_hlt   = (instr[15:12] == OP_HLT);
    // An edge only changes architectural state when neither stalled nor halted
    assign w_adv      = ~stall & ~r_halt;
    assign w_taken    = branch & w_cond & ~r_halt;

    branch_cond u_branch_cond (
        .ccc  (instr[11:9]),
        .n    (r_flags[FLAG_N]),
        .z    (r_flags[FLAG_Z]),
        .v    (r_flags[FLAG_V]),
        .cond (w_cond)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_flags <= 3'b000;
            r_halt  <= 1'b0;
        end else if (w_adv) begin
            if (w_taken) begin
                r_pc <= w_target;
            end else if (!w_is_hlt) begin
                r_pc <= w_pc_plus2;
            end
            // HLT parks the PC on its own address
            if (w_is_hlt) begin
                r_halt <= 1'b1;
            end
            if (flag_wr_z) begin
                r_flags[FLAG_Z] <= alu_z;
            end
            if (flag_wr_nv) begin
                r_flags[FLAG_N] <= alu_n;
                r_flags[FLAG_V] <= alu_v;
            end
        end
    end

    assign pc_addr      = r_pc;
    assign instr_out    = instr;
    assign pc_plus2     = w_pc_plus2;
    assign branch_taken = w_taken;
    assign halt         = r_halt;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_instr_cnt;
    logic [15:0] r_taken_cnt;

    // A stalled branch is not taken, so only advancing edges count it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= 16'h0000;
            r_taken_cnt <= 16'h0000;
        end else if (w_adv) begin
            r_instr_cnt <= r_instr_cnt + 16'd1;
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign taken_cnt = r_taken_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Self-checking bench for fetch_pc_unit: directed vector table,
//            hand-written halt/reset/counter sequences and randomized
//            stimulus against a behavioural model of the fetch stage.
// Config   : FETCH_PERF_CNT_EN also exercises the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, stall, branch, flag_wr_z, flag_wr_nv, alu_z, alu_n, alu_v;
    logic [15:0] instr, branch_reg;
    logic [15:0] pc_addr, instr_out, pc_plus2;
    logic        branch_taken, halt;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] instr_cnt, taken_cnt;
`endif

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .instr        (instr),
        .branch       (branch),
        .branch_reg   (branch_reg),
        .flag_wr_z    (flag_wr_z),
        .flag_wr_nv   (flag_wr_nv),
        .alu_z        (alu_z),
        .alu_n        (alu_n),
        .alu_v        (alu_v),
        .pc_addr      (pc_addr),
        .instr_out    (instr_out),
        .pc_plus2     (pc_plus2),
        .branch_taken (branch_taken),
        .halt         (halt)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_cnt    (instr_cnt),
        .taken_cnt    (taken_cnt)
`endif
    );

    typedef struct {
        bit          rst;
        bit          stall;
        logic [15:0] instr;
        bit          branch;
        logic [15:0] breg;
        bit          fz;
        bit          fnv;
        bit          az;
        bit          an;
        bit          av;
    } in_t;

    typedef struct {
        in_t         in;
        logic [15:0] exp_pc;
        bit          exp_taken;
        bit          exp_halt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] m_pc;
    bit          m_n, m_z, m_v, m_halt;
    int          m_icnt, m_tcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input bit r, input bit st, input logic [15:0] ins, input bit br,
                               input logic [15:0] bg, input bit fz, input bit fnv,
                               input bit az, input bit an, input bit av);
        in_t s;
        s.rst = r; s.stall = st; s.instr = ins; s.branch = br; s.breg = bg;
        s.fz = fz; s.fnv = fnv; s.az = az; s.an = an; s.av = av;
        return s;
    endfunction

    function automatic in_t plain(input logic [15:0] ins, input bit br, input logic [15:0] bg);
        return mk(1'b0, 1'b0, ins, br, bg, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Condition truth table written straight from the ccc definitions
    function automatic bit cond_of(input logic [2:0] ccc, input bit n, input bit z, input bit v);
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_taken(input in_t s);
        return s.branch && cond_of(s.instr[11:9], m_n, m_z, m_v) && !m_halt;
    endfunction

    function automatic logic [15:0] model_target(input in_t s);
        int off;
        off = s.instr[8] ? (int'(s.instr[8:0]) - 512) * 2 : int'(s.instr[8:0]) * 2;
        if (s.instr[12]) return s.breg;
        return 16'((int'(m_pc) + 2 + off) % 65536);
    endfunction

    task automatic model_edge(input in_t s);
        bit t;
        if (s.rst) begin
            m_pc = RESET_PC; m_n = 0; m_z = 0; m_v = 0; m_halt = 0;
            m_icnt = 0; m_tcnt = 0;
        end else if (!s.stall && !m_halt) begin
            t = model_taken(s);
            if (t) m_pc = model_target(s);
            else if (s.instr[15:12] != 4'hF) m_pc = 16'((int'(m_pc) + 2) % 65536);
            if (s.instr[15:12] == 4'hF) m_halt = 1;
            if (s.fz) m_z = s.az;
            if (s.fnv) begin m_n = s.an; m_v = s.av; end
            m_icnt = (m_icnt + 1) % 65536;
            if (t) m_tcnt = (m_tcnt + 1) % 65536;
        end
    endtask

    task automatic apply(input in_t s);
        rst = s.rst; stall = s.stall; instr = s.instr; branch = s.branch;
        branch_reg = s.breg; flag_wr_z = s.fz; flag_wr_nv = s.fnv;
        alu_z = s.az; alu_n = s.an; alu_v = s.av;
    endtask

    task automatic tick(input in_t s);
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc_addr"}, {16'h0, pc_addr}, {16'h0, m_pc});
        check({tag, ".pc_plus2"}, {16'h0, pc_plus2}, {16'h0, 16'((int'(m_pc) + 2) % 65536)});
        check({tag, ".instr_out"}, {16'h0, instr_out}, {16'h0, instr});
        check({tag, ".halt"}, {31'h0, halt}, {31'h0, m_halt});
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".instr_cnt"}, {16'h0, instr_cnt}, m_icnt);
        check({tag, ".taken_cnt"}, {16'h0, taken_cnt}, m_tcnt);
`endif
    endtask

    // One model-checked cycle
    task automatic mcycle(input string tag, input in_t s);
        apply(s);
        @(negedge clk);
        check_model(tag);
        check({tag, ".taken"}, {31'h0, branch_taken}, {31'h0, model_taken(s)});
        tick(s);
    endtask

    vec_t vecs[$];
    in_t  s;

    initial begin
        apply(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0, 0, 0, 0, 0, 0));
        s = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0, 0, 0, 0, 0, 0);
        tick(s);
        tick(s);

        // Directed table: {inputs, expected pc before the edge, taken, halt}
        vecs.push_back('{plain(16'h0123, 0, 16'h0), 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{plain(16'h0456, 0, 16'h0), 16'h0002, 1'b0, 1'b0});
        vecs.push_back('{mk(0, 0, 16'h1000, 0, 16'h0, 1, 0, 1, 0, 0), 16'h0004, 1'b0, 1'b0});
        vecs.push_back('{plain(16'hC203, 1, 16'h0), 16'h0006, 1'b1, 1'b0});  // EQ, Z=1
        vecs.push_back('{mk(0, 0, 16'h0000, 0, 16'h0, 1, 0, 0, 0, 0), 16'h000E, 1'b0, 1'b0});
        vecs.push_back('{plain(16'hC1FF, 1, 16'h0), 16'h0010, 1'b1, 1'b0});  // NE -1 -> self
        vecs.push_back('{plain(16'hC203, 1, 16'h0), 16'h0010, 1'b0, 1'b0});  // EQ, Z=0
        vecs.push_back('{plain(16'hDE00, 1, 16'h1234), 16'h0012, 1'b1, 1'b0});
        vecs.push_back('{mk(0, 0, 16'h1000, 0, 16'h0, 0, 1, 0, 1, 1), 16'h1234, 1'b0, 1'b0});
        vecs.push_back('{plain(16'hC602, 1, 16'h0), 16'h1236, 1'b1, 1'b0});  // LT
        vecs.push_back('{plain(16'hC402, 1, 16'h0), 16'h123C, 1'b0, 1'b0});  // GT
        vecs.push_back('{plain(16'hCC04, 1, 16'h0), 16'h123E, 1'b1, 1'b0});  // OV
        vecs.push_back('{plain(16'hC800, 1, 16'h0), 16'h1248, 1'b0, 1'b0});  // GE
        vecs.push_back('{plain(16'hCA00, 1, 16'h0), 16'h124A, 1'b1, 1'b0});  // LE
        vecs.push_back('{mk(0, 1, 16'hDE00, 1, 16'hFFFE, 0, 0, 0, 0, 0), 16'h124C, 1'b1, 1'b0});
        vecs.push_back('{plain(16'hDE00, 1, 16'hFFFE), 16'h124C, 1'b1, 1'b0});
        vecs.push_back('{plain(16'hCE00, 1, 16'h0), 16'hFFFE, 1'b1, 1'b0});  // wraps
        vecs.push_back('{plain(16'h0000, 0, 16'h0), 16'h0000, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            apply(vecs[i].in);
            @(negedge clk);
            check($sformatf("vec%0d.pc", i), {16'h0, pc_addr}, {16'h0, vecs[i].exp_pc});
            check($sformatf("vec%0d.taken", i), {31'h0, branch_taken}, {31'h0, vecs[i].exp_taken});
            check($sformatf("vec%0d.halt", i), {31'h0, halt}, {31'h0, vecs[i].exp_halt});
            tick(vecs[i].in);
        end

        // HLT at 0020, stalled for one cycle first
        mcycle("to20", plain(16'hDE00, 1, 16'h0020));
        apply(mk(0, 1, 16'hF000, 0, 16'h0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("hlt_stall.halt", {31'h0, halt}, 32'h0);
        tick(mk(0, 1, 16'hF000, 0, 16'h0, 0, 0, 0, 0, 0));
        check("hlt_stall.pc", {16'h0, pc_addr}, 32'h0020);
        check("hlt_stall.halt_after", {31'h0, halt}, 32'h0);
        mcycle("hlt", plain(16'hF000, 0, 16'h0));
        for (int k = 0; k < 5; k++) begin
            s = mk(0, 0, 16'hDE00, 1, 16'h5555, 1, 1, 1, 1, 1);
            apply(s);
            @(negedge clk);
            check("halted.pc", {16'h0, pc_addr}, 32'h0020);
            check("halted.halt", {31'h0, halt}, 32'h1);
            check("halted.taken", {31'h0, branch_taken}, 32'h0);
            tick(s);
        end
        // Reset overrides stall
        s = mk(1, 1, 16'h0000, 0, 16'h0, 0, 0, 0, 0, 0);
        apply(s);
        tick(s);
        check("rst.pc", {16'h0, pc_addr}, {16'h0, RESET_PC});
        check("rst.halt", {31'h0, halt}, 32'h0);
        check_model("rst");

`ifdef FETCH_PERF_CNT_EN
        // 10 retired instructions, 3 taken branches, last is HLT
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'hCE02, 1, 16'h0));
        mcycle("perf", mk(0, 1, 16'h0000, 0, 16'h0, 0, 0, 0, 0, 0));
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'hDE00, 1, 16'h0010));
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'hCE00, 1, 16'h0));
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'h0000, 0, 16'h0));
        mcycle("perf", plain(16'hF000, 0, 16'h0));
        for (int k = 0; k < 3; k++) begin
            mcycle("perf_frozen", plain(16'hCE00, 1, 16'h0));
            check("perf.instr_cnt", {16'h0, instr_cnt}, 32'd10);
            check("perf.taken_cnt", {16'h0, taken_cnt}, 32'd3);
        end
        s = mk(1, 0, 16'h0000, 0, 16'h0, 0, 0, 0, 0, 0);
        apply(s);
        tick(s);
`endif

        // Randomized stimulus against the model
        for (int k = 0; k < 600; k++) begin
            s.rst    = ($urandom_range(0, 99) < 2) || (m_halt && ($urandom_range(0, 3) == 0));
            s.stall  = ($urandom_range(0, 4) == 0);
            s.instr  = 16'($urandom);
            s.branch = (s.instr[15:12] == 4'hC) || (s.instr[15:12] == 4'hD);
            s.breg   = 16'($urandom);
            s.fz     = 1'($urandom);
            s.fnv    = 1'($urandom);
            s.az     = 1'($urandom);
            s.an     = 1'($urandom);
            s.av     = 1'($urandom);
            mcycle("rand", s);
        end
        check_model("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
